// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory arbiter: request kinds, master
// indices and the one-deep pending slot record.
`timescale 1ns/1ps
package mem_arb_pkg;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_MASK_W = ARB_DATA_W / 8;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2
  } req_kind_e;

  typedef struct packed {
    req_kind_e               kind;
    logic [ARB_ADDR_W-1:0]   addr;
    logic [ARB_DATA_W-1:0]   wdata;
    logic [ARB_MASK_W-1:0]   wmask;
  } slot_t;

  // A write strobe outranks a read pulse issued in the same cycle.
  function automatic req_kind_e req_kind(input logic rstrb, input logic [ARB_MASK_W-1:0] wmask);
    req_kind_e k;
    k = REQ_NONE;
    if (|wmask) k = REQ_WRITE;
    else if (rstrb) k = REQ_READ;
    return k;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// rstrb/wmask memory bus. slave: arbiter side of a master port;
// mem_port: arbiter side facing the single-port memory.
`timescale 1ns/1ps
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wmask;
  logic                rstrb;
  logic [DATA_W-1:0]   rdata;
  logic                rbusy;
  logic                wbusy;

  modport master   (output addr, wdata, wmask, rstrb, input  rdata, rbusy, wbusy);
  modport slave    (input  addr, wdata, wmask, rstrb, output rdata, rbusy, wbusy);
  modport mem_port (output addr, wdata, wmask, rstrb, input  rdata);
endinterface

// File: rtl/mem_arb_slot.sv
// Per-master request slot: captures a losing request, exposes busy flags and
// returns read data (pass-through on the return cycle, held otherwise).
`timescale 1ns/1ps
module mem_arb_slot
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  slot_t             live_i,
  input  logic              grant_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  output slot_t             cur_o,
  output logic              elig_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rbusy_o,
  output logic              wbusy_o
);
  slot_t             slot_q, slot_d;
  logic              rvld_q, rvld_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              pend;

  assign pend   = (slot_q.kind != REQ_NONE);
  // A pending slot shadows the live inputs; new requests then are dropped.
  assign cur_o  = pend ? slot_q : live_i;
  assign elig_o = (cur_o.kind != REQ_NONE);

  always_comb begin
    slot_d = slot_q;
    if (pend) begin
      if (grant_i) slot_d = '0;
    end else if (live_i.kind != REQ_NONE && !grant_i) begin
      slot_d = live_i;
    end
  end

  assign rvld_d  = grant_i && (cur_o.kind == REQ_READ);
  assign hold_d  = rvld_q ? s_rdata_i : hold_q;
  assign rdata_o = rvld_q ? s_rdata_i : hold_q;
  assign rbusy_o = (slot_q.kind == REQ_READ);
  assign wbusy_o = (slot_q.kind == REQ_WRITE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      slot_q <= '0;
      rvld_q <= 1'b0;
      hold_q <= '0;
    end else begin
      slot_q <= slot_d;
      rvld_q <= rvld_d;
      hold_q <= hold_d;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of the single-port SOC memory. Round-robin by
// default; define MEM_ARB_FIXED_PRIO_EN to give M0 absolute priority.
`timescale 1ns/1ps
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int RR_INIT = 0
) (
  input logic            clk,
  input logic            resetn,
  mem_arbiter_if.slave    m0,
  mem_arbiter_if.slave    m1,
  mem_arbiter_if.mem_port s
);
  slot_t [1:0]             live, cur;
  logic  [1:0]             elig, grant, rbusy, wbusy;
  logic  [1:0][DATA_W-1:0] rdata;
  slot_t                   sel;
  logic  [ADDR_W-1:0]      s_addr_d;

  assign live[M0] = '{kind: req_kind(m0.rstrb, m0.wmask), addr: m0.addr, wdata: m0.wdata, wmask: m0.wmask};
  assign live[M1] = '{kind: req_kind(m1.rstrb, m1.wmask), addr: m1.addr, wdata: m1.wdata, wmask: m1.wmask};

  for (genvar g = 0; g < 2; g++) begin : g_slot
    mem_arb_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .resetn    (resetn),
      .live_i    (live[g]),
      .grant_i   (grant[g]),
      .s_rdata_i (s.rdata),
      .cur_o     (cur[g]),
      .elig_o    (elig[g]),
      .rdata_o   (rdata[g]),
      .rbusy_o   (rbusy[g]),
      .wbusy_o   (wbusy[g])
    );
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    if (elig[M0])      grant[M0] = 1'b1;
    else if (elig[M1]) grant[M1] = 1'b1;
  end
`else
  logic last_q, last_d;

  // Under contention the master that did not win last time goes first.
  always_comb begin
    grant = elig;
    if (&elig) begin
      grant = '0;
      if (last_q == M0) grant[M1] = 1'b1;
      else              grant[M0] = 1'b1;
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant[M1])      last_d = M1;
    else if (grant[M0]) last_d = M0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) last_q <= 1'(RR_INIT);
    else         last_q <= last_d;
  end
`endif

  assign sel = grant[M1] ? cur[M1] : cur[M0];

  // Strobes are gated by reset so nothing reaches memory in a reset cycle.
  always_comb begin
    s_addr_d = m0.addr;
    s.wdata  = m0.wdata;
    s.wmask  = '0;
    s.rstrb  = 1'b0;
    if (resetn && (|grant)) begin
      s_addr_d = sel.addr;
      s.wdata  = sel.wdata;
      s.wmask  = (sel.kind == REQ_WRITE) ? sel.wmask : '0;
      s.rstrb  = (sel.kind == REQ_READ);
    end
  end
  assign s.addr = s_addr_d;

  assign m0.rdata = rdata[M0];
  assign m0.rbusy = rbusy[M0];
  assign m0.wbusy = wbusy[M0];
  assign m1.rdata = rdata[M1];
  assign m1.rbusy = rbusy[M1];
  assign m1.wbusy = wbusy[M1];
endmodule
